// File: rtl/xfindmax_gather_if.sv
// Sample-in / vector-out bus between the gather stage and its neighbours.
// The slave side is the gatherer; the master side feeds samples and consumes the
// packed vector that goes on to the max-finder tree.
interface xfindmax_gather_if #(
   parameter int unsigned NEl  = 8,
   parameter int unsigned BWID = 16,
   parameter int unsigned IWID = 4,
   parameter int unsigned CWID = 8
) ();

   // Sample stream
   logic [BWID-1:0]     i_data;
   logic                i_vld;
   logic                i_last;

   // Packed vector towards the tree
   logic [BWID*NEl-1:0] ov_data;
   logic [IWID*NEl-1:0] ov_index;
   logic                o_nd;
   logic [IWID-1:0]     o_nvalid;
   logic [CWID-1:0]     o_blk;
   logic                o_last;

   modport master (
      output i_data,
      output i_vld,
      output i_last,
      input  ov_data,
      input  ov_index,
      input  o_nd,
      input  o_nvalid,
      input  o_blk,
      input  o_last
   );

   modport slave (
      input  i_data,
      input  i_vld,
      input  i_last,
      output ov_data,
      output ov_index,
      output o_nd,
      output o_nvalid,
      output o_blk,
      output o_last
   );

endinterface

// File: rtl/xfindmax_gather.sv
// Gathers NEl consecutive unsigned samples into one wide vector with per-lane
// indices for the pipelined max-finder tree. A short end-of-frame block is
// padded with data 0 / index 0 so a pad lane can at most tie (the tree uses a
// strict >), and when all real lanes are 0 the pad index still names lane 0.
module xfindmax_gather #(
   parameter int unsigned NEl  = 8,
   parameter int unsigned BWID = 16,
   parameter int unsigned IWID = 4,
   parameter int unsigned CWID = 8
) (
   input logic               clk,
   input logic               rst,
   xfindmax_gather_if.slave  bus_io
);

   localparam int unsigned CntW = (NEl > 1) ? $clog2(NEl) : 1;

   typedef logic [CntW-1:0] cnt_t;

   // Sample bank and counters
   logic [BWID-1:0]     bank_q [NEl];
   cnt_t                cnt_q, cnt_d;
   logic [CWID-1:0]     blk_q, blk_d;
   logic                trig;

   // Registered outputs and their next-state values
   logic [BWID*NEl-1:0] data_q, data_d;
   logic [IWID*NEl-1:0] index_q, index_d;
   logic                nd_q;
   logic [IWID-1:0]     nvalid_q, nvalid_d;
   logic [CWID-1:0]     oblk_q;
   logic                last_q;

   // A block closes when its last lane fills or the frame ends early.
   assign trig = bus_io.i_vld && ((cnt_q == cnt_t'(NEl - 1)) || bus_io.i_last);

   // Merge the bank with the current sample into the outgoing lane layout.
   always_comb begin
      data_d  = '0;
      index_d = '0;
      for (int unsigned k = 0; k < NEl; k++) begin
         if (cnt_t'(k) < cnt_q) begin
            data_d[BWID*k +: BWID]  = bank_q[k];
            index_d[IWID*k +: IWID] = IWID'(k);
         end else if (cnt_t'(k) == cnt_q) begin
            // Current sample bypasses the bank so emission costs no extra cycle
            data_d[BWID*k +: BWID]  = bus_io.i_data;
            index_d[IWID*k +: IWID] = IWID'(k);
         end
      end
      nvalid_d = IWID'(cnt_q) + IWID'(1);
   end

   // Lane and block counter next state.
   always_comb begin
      cnt_d = cnt_q;
      blk_d = blk_q;
      if (bus_io.i_vld) begin
         cnt_d = trig ? '0 : cnt_q + cnt_t'(1);
      end
      if (trig) begin
         blk_d = bus_io.i_last ? '0 : blk_q + CWID'(1);
      end
   end

   // State and output registers; reset drops any partial block.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned k = 0; k < NEl; k++) begin
            bank_q[k] <= '0;
         end
         cnt_q    <= '0;
         blk_q    <= '0;
         data_q   <= '0;
         index_q  <= '0;
         nd_q     <= 1'b0;
         nvalid_q <= '0;
         oblk_q   <= '0;
         last_q   <= 1'b0;
      end else begin
         if (bus_io.i_vld) begin
            bank_q[cnt_q] <= bus_io.i_data;
         end
         cnt_q <= cnt_d;
         blk_q <= blk_d;
         nd_q  <= trig;
         if (trig) begin
            data_q   <= data_d;
            index_q  <= index_d;
            nvalid_q <= nvalid_d;
            oblk_q   <= blk_q;
            last_q   <= bus_io.i_last;
         end
      end
   end

   assign bus_io.ov_data  = data_q;
   assign bus_io.ov_index = index_q;
   assign bus_io.o_nd     = nd_q;
   assign bus_io.o_nvalid = nvalid_q;
   assign bus_io.o_blk    = oblk_q;
   assign bus_io.o_last   = last_q;

endmodule

// File: tb/tb_xfindmax_gather.sv
// Self-checking bench for xfindmax_gather: table vectors, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_xfindmax_gather;

   localparam int unsigned NEl  = 8;
   localparam int unsigned BWID = 16;
   localparam int unsigned IWID = 4;
   localparam int unsigned CWID = 8;

   logic clk;
   logic rst;

   xfindmax_gather_if #(.NEl(NEl), .BWID(BWID), .IWID(IWID), .CWID(CWID)) bus ();

   xfindmax_gather #(.NEl(NEl), .BWID(BWID), .IWID(IWID), .CWID(CWID)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks;
   int failures;

   // Reference model: samples of the open block, frame block number, and the
   // output values the spec says should currently be visible.
   logic [BWID-1:0]     mq[$];
   int unsigned         mblk;
   logic [BWID*NEl-1:0] e_data;
   logic [IWID*NEl-1:0] e_index;
   logic                e_nd;
   logic [IWID-1:0]     e_nvalid;
   logic [CWID-1:0]     e_blk;
   logic                e_last;

   typedef struct {
      logic            v;
      logic            l;
      logic [BWID-1:0] d;
      logic            nd;
      logic [IWID-1:0] nvalid;
      logic [CWID-1:0] blk;
      logic            last;
   } vec_t;

   vec_t t1[9];
   vec_t t3[4];

   function automatic void chk(input string name, input logic [127:0] act,
                               input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   function automatic void model_clear();
      mq.delete();
      mblk     = 0;
      e_data   = '0;
      e_index  = '0;
      e_nd     = 1'b0;
      e_nvalid = '0;
      e_blk    = '0;
      e_last   = 1'b0;
   endfunction

   function automatic void model_edge(input logic v, input logic l, input logic [BWID-1:0] d);
      e_nd = 1'b0;
      if (v) begin
         mq.push_back(d);
         if (mq.size() == NEl || l) begin
            e_nd    = 1'b1;
            e_data  = '0;
            e_index = '0;
            for (int i = 0; i < mq.size(); i++) begin
               e_data[BWID*i +: BWID]  = mq[i];
               e_index[IWID*i +: IWID] = IWID'(i);
            end
            e_nvalid = IWID'(mq.size());
            e_blk    = CWID'(mblk);
            e_last   = l;
            mblk     = l ? 0 : (mblk + 1) % 256;
            mq.delete();
         end
      end
   endfunction

   task automatic check_model(input string tag);
      chk({tag, "_nd"},     128'(bus.o_nd),     128'(e_nd));
      chk({tag, "_data"},   128'(bus.ov_data),  128'(e_data));
      chk({tag, "_index"},  128'(bus.ov_index), 128'(e_index));
      chk({tag, "_nvalid"}, 128'(bus.o_nvalid), 128'(e_nvalid));
      chk({tag, "_blk"},    128'(bus.o_blk),    128'(e_blk));
      chk({tag, "_last"},   128'(bus.o_last),   128'(e_last));
   endtask

   task automatic step(input logic v, input logic l, input logic [BWID-1:0] d,
                       input string tag);
      bus.i_vld  = v;
      bus.i_last = l;
      bus.i_data = d;
      @(posedge clk);
      model_edge(v, l, d);
      #1;
      check_model(tag);
   endtask

   task automatic do_reset(input logic v, input logic l, input logic [BWID-1:0] d);
      rst        = 1'b1;
      bus.i_vld  = v;
      bus.i_last = l;
      bus.i_data = d;
      @(posedge clk);
      model_clear();
      #1;
      check_model("reset");
      rst = 1'b0;
   endtask

   task automatic apply_vec(input vec_t r, input string tag);
      step(r.v, r.l, r.d, tag);
      chk({tag, "_tbl_nd"}, 128'(bus.o_nd), 128'(r.nd));
      if (r.nd) begin
         chk({tag, "_tbl_nvalid"}, 128'(bus.o_nvalid), 128'(r.nvalid));
         chk({tag, "_tbl_blk"},    128'(bus.o_blk),    128'(r.blk));
         chk({tag, "_tbl_last"},   128'(bus.o_last),   128'(r.last));
      end
   endtask

   initial begin
      logic [BWID*NEl-1:0] exp_vec;
      logic [IWID*NEl-1:0] exp_idx;
      int                  nd_cnt;
      int                  nd_at[$];
      logic                prev_nd;

      checks   = 0;
      failures = 0;
      rst      = 1'b0;
      bus.i_vld  = 1'b0;
      bus.i_last = 1'b0;
      bus.i_data = '0;

      // Vector tables
      for (int i = 0; i < 8; i++) begin
         t1[i] = '{v: 1'b1, l: 1'b0, d: BWID'(10 * (i + 1)), nd: 1'b0, nvalid: '0,
                   blk: '0, last: 1'b0};
      end
      t1[7].nd     = 1'b1;
      t1[7].nvalid = 4'd8;
      t1[8] = '{v: 1'b0, l: 1'b0, d: '0, nd: 1'b0, nvalid: '0, blk: '0, last: 1'b0};

      t3[0] = '{v: 1'b1, l: 1'b0, d: 16'd5, nd: 1'b0, nvalid: '0, blk: '0, last: 1'b0};
      t3[1] = '{v: 1'b1, l: 1'b0, d: 16'd9, nd: 1'b0, nvalid: '0, blk: '0, last: 1'b0};
      // Block number 1: the preceding full block did not close its frame
      t3[2] = '{v: 1'b1, l: 1'b1, d: 16'd7, nd: 1'b1, nvalid: 4'd3, blk: 8'd1, last: 1'b1};
      t3[3] = '{v: 1'b0, l: 1'b0, d: '0, nd: 1'b0, nvalid: '0, blk: '0, last: 1'b0};

      do_reset(1'b0, 1'b0, '0);

      // Full block 10..80
      for (int i = 0; i < 9; i++) apply_vec(t1[i], "t1");
      for (int k = 0; k < 8; k++) begin
         chk("t1_lane_data", 128'(bus.ov_data[BWID*k +: BWID]), 128'(10 * (k + 1)));
         chk("t1_lane_index", 128'(bus.ov_index[IWID*k +: IWID]), 128'(k));
      end

      // Short frame 5,9,7
      for (int i = 0; i < 4; i++) apply_vec(t3[i], "t3");
      exp_vec = '0;
      exp_vec[15:0] = 16'd5;
      exp_vec[31:16] = 16'd9;
      exp_vec[47:32] = 16'd7;
      exp_idx = 32'h0000_0210;
      chk("t3_vec_data",  128'(bus.ov_data),  128'(exp_vec));
      chk("t3_vec_index", 128'(bus.ov_index), 128'(exp_idx));

      // One-sample frame of value 0
      step(1'b1, 1'b1, 16'd0, "t4");
      chk("t4_nd",     128'(bus.o_nd),     128'd1);
      chk("t4_data",   128'(bus.ov_data),  128'd0);
      chk("t4_index",  128'(bus.ov_index), 128'd0);
      chk("t4_nvalid", 128'(bus.o_nvalid), 128'd1);

      // 24 samples with i_last on the 24th, then one more full block
      nd_at.delete();
      for (int i = 0; i < 32; i++) begin
         step(1'b1, (i == 23), BWID'(100 + i), "t2");
         if (bus.o_nd) begin
            nd_at.push_back(i);
            chk("t2_blk", 128'(bus.o_blk), (nd_at.size() == 4) ? 128'd0 :
                128'(nd_at.size() - 1));
            chk("t2_last", 128'(bus.o_last), 128'(nd_at.size() == 3));
         end
      end
      chk("t2_nd_count", 128'(nd_at.size()), 128'd4);
      if (nd_at.size() >= 3) begin
         chk("t2_spacing_a", 128'(nd_at[1] - nd_at[0]), 128'd8);
         chk("t2_spacing_b", 128'(nd_at[2] - nd_at[1]), 128'd8);
      end

      // Partial block with gaps, discarded by reset (rst wins over a last sample)
      nd_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, BWID'(500 + i), "t5_part");
         nd_cnt += int'(bus.o_nd);
         step(1'b0, 1'b0, '0, "t5_gap");
         nd_cnt += int'(bus.o_nd);
         step(1'b0, 1'b1, '0, "t5_gap");
         nd_cnt += int'(bus.o_nd);
      end
      do_reset(1'b1, 1'b1, 16'hdead);
      nd_cnt += int'(bus.o_nd);
      step(1'b0, 1'b0, '0, "t5_post");
      nd_cnt += int'(bus.o_nd);
      chk("t5_no_partial_nd", 128'(nd_cnt), 128'd0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, BWID'(700 + i), "t5_fresh");
      chk("t5_fresh_nd", 128'(bus.o_nd), 128'd1);
      chk("t5_fresh_blk", 128'(bus.o_blk), 128'd0);
      for (int k = 0; k < 8; k++) begin
         chk("t5_fresh_lane", 128'(bus.ov_data[BWID*k +: BWID]), 128'(700 + k));
      end

      // 257 full blocks: block counter wrap
      do_reset(1'b0, 1'b0, '0);
      nd_cnt  = 0;
      prev_nd = 1'b0;
      for (int i = 0; i < 257 * 8; i++) begin
         step(1'b1, 1'b0, BWID'($urandom), "t6");
         chk("t6_no_back2back", 128'(prev_nd & bus.o_nd), 128'd0);
         if (bus.o_nd) begin
            chk("t6_blk", 128'(bus.o_blk), 128'(nd_cnt % 256));
            nd_cnt++;
         end
         prev_nd = bus.o_nd;
      end
      chk("t6_nd_count", 128'(nd_cnt), 128'd257);
      chk("t6_wrap_blk", 128'(bus.o_blk), 128'd0);

      // Random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(199) == 0) begin
            do_reset(1'($urandom), 1'($urandom), BWID'($urandom));
         end else begin
            step(($urandom_range(9) < 7), ($urandom_range(9) == 0),
                 ($urandom_range(7) == 0) ? '0 : BWID'($urandom), "rand");
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/xfindmax_gather.md
Name: xfindmax_gather

Overview:
- Upstream feeder for the pipelined max-finder tree.
- Accepts one sample per cycle and packs NEl consecutive samples into one wide vector, with a per-lane index for each sample.
- Issues the vector with a one-cycle new-data strobe, in the exact bus layout the tree consumes.
- Short end-of-frame blocks are padded so that padding lanes can never win the max.

Parameters:
NEl, 8, lanes per output vector; power of two, >= 2
BWID, 16, sample width (unsigned)
IWID, 4, per-lane index width = number of bits needed to represent NEl (4 for NEl=8), matching the tree's index lane width
CWID, 8, block-within-frame counter width

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  reset: synchronous, active-high
i_data  input  BWID  sample
i_vld  input  1  sample valid; accepted every cycle it is high (no backpressure)
i_last  input  1  sample is the last of its frame; qualified by i_vld
ov_data  output  BWID*NEl  packed vector; lane k at bits [BWID*(k+1)-1 : BWID*k]
ov_index  output  IWID*NEl  packed indices; lane k at bits [IWID*(k+1)-1 : IWID*k]
o_nd  output  1  one-cycle strobe: ov_* valid, feeds tree i_nd
o_nvalid  output  IWID  number of real (non-pad) lanes in the emitted vector, 1..NEl
o_blk  output  CWID  block number within the current frame for the emitted vector
o_last  output  1  emitted vector closes a frame

Behaviour:
- Reset (rst=1 at an edge):
  - internal lane counter = 0, block counter = 0;
  - ov_data = 0, ov_index = 0, o_nd = 0, o_nvalid = 0, o_blk = 0, o_last = 0;
  - any partially gathered samples are discarded and never emitted.
- Accumulation: on an edge with i_vld=1, i_data is written into bank lane cnt, where cnt is the lane counter.
- Emission trigger: (i_vld=1 and cnt==NEl-1) or (i_vld=1 and i_last=1).
- On the edge where the trigger is true:
  - output registers load from the bank, with the current sample merged into lane cnt;
  - lanes 0..cnt carry real data with index = lane number;
  - lanes cnt+1..NEl-1 carry data 0 and index 0;
  - o_nvalid = cnt+1; o_blk = current block counter; o_last = i_last; o_nd = 1 for exactly the following cycle;
  - lane counter returns to 0.
- Latency: o_nd asserts one cycle after the triggering sample.
  - A sample arriving on the very next edge goes to lane 0 of the next block.
  - Back-to-back blocks at full rate are supported: one o_nd every NEl cycles when i_vld is held high.
- Holding: ov_data, ov_index, o_nvalid, o_blk and o_last hold their values until the next emission. o_nd is 0 whenever no emission occurred on the previous edge.
- Idle: i_vld=0 leaves the bank and counters unchanged, so gaps inside a block are allowed. i_last is ignored when i_vld=0.
- Block counter:
  - increments on each emission with o_last=0;
  - clears to 0 on an emission with o_last=1;
  - wraps modulo 2^CWID.
- Padding rationale:
  - Samples are unsigned and the tree uses strict >, so a pad of 0 can only tie, never exceed.
  - If every real lane is 0, pad index 0 still names a real zero lane.
- i_last on the NEl-th lane: a single emission with o_nvalid=NEl and o_last=1; no empty trailing block.
- Lane-0 i_last: one-sample frame; o_nvalid=1 and lanes 1..NEl-1 padded.
- rst has priority over i_vld in the same cycle.

Test Plan:
1. Reset, then i_vld=1 for 8 cycles with data 10,20,...,80 and i_last=0.
   - Required: exactly one o_nd, on the cycle after the 8th sample.
   - ov_data lanes = 10..80; ov_index lanes = 0..7; o_nvalid=8; o_blk=0; o_last=0.
2. Continuous 24 samples with i_last on the 24th.
   - Required: o_nd three times, 8 cycles apart, with o_blk = 0, 1, 2.
   - o_last=1 only on the third; the next frame starts at o_blk=0.
3. Frame of 3 samples 5,9,7 with i_last on the third.
   - Required: lanes 0-2 = 5,9,7 with index 0,1,2.
   - Lanes 3-7 data 0, index 0; o_nvalid=3; o_last=1.
4. Single-sample frame with value 0 and i_last=1.
   - Required: all lanes data 0, all indices 0; o_nvalid=1.
5. Samples in lanes 0-4 with i_vld gaps of 2 idle cycles between them, then rst=1 for 1 cycle, then 8 fresh samples.
   - Required: no o_nd from the discarded partial block.
   - The first emission contains only the fresh samples, with o_blk=0.
6. 257 full blocks without i_last (CWID=8).
   - Required: o_blk runs 0..255, then wraps to 0 on block 257.
   - o_nd is never asserted for 2 consecutive cycles.
